window_crop_multi: RTL and testbench
====================================

// Module: window_crop_multi
// PURPOSE
//  Parametrised N-channel crop/decimate stage for the camera pixel pipeline. It replaces fixed
//  pan/zoom crops with a runtime window and power-of-two decimation. It sits between the
//  byte-to-pixel output and debayer (raw, BAYER_MODE=1), or between debayer and jpeg (RGB, CHANNELS=3).
//  Window changes are shadowed and take effect only at a frame boundary, so frames never tear.
// PARAMETERS
//  CHANNELS     1    colour channels carried in parallel
//  DATA_WIDTH   10   bits per channel
//  COORD_WIDTH  12   width of x/y counters and window coordinates
//  MAX_DECIM    3    largest decimation shift accepted (factor 2^shift)
//  BAYER_MODE   0    1: decimation keeps 2x2 quads, so the CFA pattern survives
//  RESET_X_S/E  0/720, RESET_Y_S/E 0/720   active window after reset
// PORTS
//  pixel_clock_in     in   1                    pixel clock, 36 MHz
//  mipi_byte_reset_n  in   1                    reset, asynchronous, active-low
//  data_in            in   CHANNELS*DATA_WIDTH  pixel, channel 0 in LSBs
//  line_valid_in      in   1                    line valid
//  frame_valid_in     in   1                    frame valid
//  x_start_in/x_end_in in  COORD_WIDTH          column window, start inclusive, end exclusive
//  y_start_in/y_end_in in  COORD_WIDTH          row window, start inclusive, end exclusive
//  decim_in           in   2                    decimation shift
//  config_valid_in    in   1                    one-cycle strobe; samples the five config inputs
//  data_out           out  CHANNELS*DATA_WIDTH  cropped pixel
//  line_valid_out     out  1                    output line valid
//  frame_valid_out    out  1                    output frame valid
//  config_applied_out out  1                    one-cycle pulse when pending config goes active
//  window_error_out   out  1                    sticky: last config rejected
//  frame_count_out    out  16                   frames emitted, wraps
// BEHAVIOUR
//  Reset: all outputs 0. Active window = RESET_*; no config pending.
//  Latency: exactly 1 cycle, data_in to data_out. data_out holds its last value while line_valid_out=0.
//  Sync: after reset, input is ignored until the first rising edge of frame_valid_in.
//   A frame already in progress at reset release is dropped whole.
//  Counters: x counts line_valid_in cycles and clears when line_valid_in falls.
//   y increments on each falling edge of line_valid_in and clears on the rising edge of frame_valid_in.
//  Keep condition: x_start<=x<x_end and y_start<=y<y_end, plus the decimation test:
//   - BAYER_MODE=0: (x-x_start) and (y-y_start) are both multiples of 2^decim.
//   - BAYER_MODE=1: ((x-x_start)>>1) and ((y-y_start)>>1) are both multiples of 2^decim.
//   line_valid_out is the registered keep condition.
//  frame_valid_out rises with the first line_valid_out of a frame.
//   It falls 1 cycle after frame_valid_in falls.
//   If the window lies outside the frame, it stays low for that frame.
//  Config path: config_valid_in is checked in the same cycle it is sampled.
//   - Reject if x_end<=x_start, y_end<=y_start, or decim>MAX_DECIM.
//   - On reject: window_error_out=1, pending is unchanged.
//   - On accept: window_error_out=0, value goes to the pending register.
//   A newer accepted config overwrites an older pending one.
//  Apply: on the frame_valid_in rising edge, a pending config is copied to active, pending clears,
//   and config_applied_out pulses.
//   If config_valid_in coincides with that edge and is accepted, it applies to the frame starting now.
//  frame_count_out increments on each falling edge of frame_valid_out. FFFF wraps to 0000.
//  Mid-frame config never changes the active window.
//  Mid-frame reset returns the block to the sync-wait state.
//  Counter overflow (x or y reaching 2^COORD_WIDTH-1) saturates; no output outside the window.
// STRUCTURE
//  camera_pkg gets: typedef window_t (x_start, x_end, y_start, y_end, decim), RESET_WINDOW constant,
//   function window_ok().
//  Sub-module window_counter: x/y counters, edge detectors, sync flag.
//  Top level: shadow/active registers, keep logic, output register.
//  One always_ff per clock. Every flop uses the async reset.
// TESTING
//  1 Defaults, 1280x728 ramp frame -> exactly 720 lines of 720 pixels.
//    First output pixel = input (0,0), latency 1; frame_count_out=1.
//  2 Config (284,1004,4,724,decim 0) mid-frame -> current frame keeps the old window.
//    Next frame has first pixel (284,4); config_applied_out pulses once, at that frame's start.
//  3 decim=1, BAYER_MODE=0, window 0..8 x 0..4 -> 4x2 pixels: x 0,2,4,6; y 0,2.
//    Same test with BAYER_MODE=1 -> x 0,1,4,5; y 0,1.
//  4 Config x_end=x_start=100 -> window_error_out=1, no apply at next frame.
//    A following valid config -> error clears and the config applies.
//  5 Reset asserted mid-line, released mid-frame -> zero output for the rest of that frame.
//    Next frame is cropped normally.
//  6 Window y_start=800 on a 728-line frame -> frame_valid_out stays low, count does not change.
//    Also drive config_valid_in on the frame_valid_in rising edge -> that config applies to the same frame.

Source files
------------

// File: rtl/camera_pkg.sv
// Shared window type, reset window and config validation for the camera crop stage.
package camera_pkg;

    localparam int unsigned WIN_COORD_WIDTH = 16;
    localparam int unsigned DECIM_WIDTH     = 2;

    typedef struct packed {
        logic [WIN_COORD_WIDTH-1:0] x_start;
        logic [WIN_COORD_WIDTH-1:0] x_end;
        logic [WIN_COORD_WIDTH-1:0] y_start;
        logic [WIN_COORD_WIDTH-1:0] y_end;
        logic [DECIM_WIDTH-1:0]     decim;
    } window_t;

    localparam window_t RESET_WINDOW = '{
        x_start: 16'd0,
        x_end:   16'd720,
        y_start: 16'd0,
        y_end:   16'd720,
        decim:   2'd0
    };

    function automatic logic window_ok(input window_t w, input int unsigned max_decim);
        return (w.x_end > w.x_start) && (w.y_end > w.y_start) && (32'(w.decim) <= max_decim);
    endfunction

endpackage

// File: rtl/window_counter.sv
// Pixel x/y position tracking, line/frame edge detection and post-reset frame sync.
module window_counter #(
    parameter int unsigned COORD_WIDTH = 12
) (
    input  logic                   pixel_clock_in,
    input  logic                   mipi_byte_reset_n,
    input  logic                   line_valid,
    input  logic                   frame_valid,
    output logic [COORD_WIDTH-1:0] x,
    output logic [COORD_WIDTH-1:0] y,
    output logic                   frame_start,
    output logic                   synced
);

    localparam logic [COORD_WIDTH-1:0] COORD_MAX = '1;

    logic [COORD_WIDTH-1:0] x_q, x_d;
    logic [COORD_WIDTH-1:0] y_q, y_d;
    logic                   line_valid_q;
    logic                   frame_valid_q;
    logic                   synced_q;
    logic                   line_end;

    always_comb begin
        frame_start = frame_valid & ~frame_valid_q;
        line_end    = ~line_valid & line_valid_q;

        x_d = '0;
        if (line_valid) begin
            x_d = (x_q == COORD_MAX) ? x_q : x_q + 1'b1;
        end

        y_d = y_q;
        if (frame_start) begin
            y_d = '0;
        end else if (line_end && (y_q != COORD_MAX)) begin
            y_d = y_q + 1'b1;
        end

        x      = x_q;
        y      = frame_start ? '0 : y_q;
        synced = synced_q | frame_start;
    end

    // frame_valid_q resets high so a frame already running at reset release is not a start.
    always_ff @(posedge pixel_clock_in or negedge mipi_byte_reset_n) begin
        if (!mipi_byte_reset_n) begin
            x_q           <= '0;
            y_q           <= '0;
            line_valid_q  <= 1'b0;
            frame_valid_q <= 1'b1;
            synced_q      <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            line_valid_q  <= line_valid;
            frame_valid_q <= frame_valid;
            synced_q      <= synced_q | frame_start;
        end
    end

endmodule

// File: rtl/window_crop_multi.sv
// N-channel runtime crop/decimate stage; window changes are shadowed until the next frame start.
module window_crop_multi
    import camera_pkg::*;
#(
    parameter int unsigned CHANNELS    = 1,
    parameter int unsigned DATA_WIDTH  = 10,
    parameter int unsigned COORD_WIDTH = 12,
    parameter int unsigned MAX_DECIM   = 3,
    parameter int unsigned BAYER_MODE  = 0,
    parameter int unsigned RESET_X_S   = 32'(RESET_WINDOW.x_start),
    parameter int unsigned RESET_X_E   = 32'(RESET_WINDOW.x_end),
    parameter int unsigned RESET_Y_S   = 32'(RESET_WINDOW.y_start),
    parameter int unsigned RESET_Y_E   = 32'(RESET_WINDOW.y_end)
) (
    input  logic                           pixel_clock_in,
    input  logic                           mipi_byte_reset_n,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
    input  logic                           line_valid_in,
    input  logic                           frame_valid_in,
    input  logic [COORD_WIDTH-1:0]         x_start_in,
    input  logic [COORD_WIDTH-1:0]         x_end_in,
    input  logic [COORD_WIDTH-1:0]         y_start_in,
    input  logic [COORD_WIDTH-1:0]         y_end_in,
    input  logic [DECIM_WIDTH-1:0]         decim_in,
    input  logic                           config_valid_in,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
    output logic                           line_valid_out,
    output logic                           frame_valid_out,
    output logic                           config_applied_out,
    output logic                           window_error_out,
    output logic [15:0]                    frame_count_out
);

    localparam int unsigned PIX_WIDTH = CHANNELS * DATA_WIDTH;

    localparam window_t ACTIVE_RESET = '{
        x_start: WIN_COORD_WIDTH'(RESET_X_S),
        x_end:   WIN_COORD_WIDTH'(RESET_X_E),
        y_start: WIN_COORD_WIDTH'(RESET_Y_S),
        y_end:   WIN_COORD_WIDTH'(RESET_Y_E),
        decim:   '0
    };

    logic [COORD_WIDTH-1:0] x;
    logic [COORD_WIDTH-1:0] y;
    logic                   frame_start;
    logic                   synced;

    window_counter #(
        .COORD_WIDTH(COORD_WIDTH)
    ) u_counter (
        .pixel_clock_in   (pixel_clock_in),
        .mipi_byte_reset_n(mipi_byte_reset_n),
        .line_valid       (line_valid_in),
        .frame_valid      (frame_valid_in),
        .x                (x),
        .y                (y),
        .frame_start      (frame_start),
        .synced           (synced)
    );

    window_t              active_q, active_d;
    window_t              pending_q, pending_d;
    logic                 pending_valid_q, pending_valid_d;
    logic                 error_q, error_d;
    logic                 applied_q, applied_d;
    logic [PIX_WIDTH-1:0] data_q, data_d;
    logic                 line_valid_q, line_valid_d;
    logic                 frame_valid_q, frame_valid_d;
    logic [15:0]          frame_count_q, frame_count_d;

    window_t                    config_win;
    logic                       config_ok;
    logic                       config_accept;
    logic [WIN_COORD_WIDTH-1:0] x_ext, y_ext, dx, dy, step_mask;
    logic                       in_window;
    logic                       keep;

    always_comb begin
        config_win.x_start = WIN_COORD_WIDTH'(x_start_in);
        config_win.x_end   = WIN_COORD_WIDTH'(x_end_in);
        config_win.y_start = WIN_COORD_WIDTH'(y_start_in);
        config_win.y_end   = WIN_COORD_WIDTH'(y_end_in);
        config_win.decim   = decim_in;
        config_ok          = window_ok(config_win, MAX_DECIM);
        config_accept      = config_valid_in & config_ok;

        // A config accepted on the frame-start edge bypasses pending and applies at once.
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        if (frame_start) begin
            if (config_accept) begin
                active_d = config_win;
            end else if (pending_valid_q) begin
                active_d = pending_q;
            end
            pending_valid_d = 1'b0;
        end else if (config_accept) begin
            pending_d       = config_win;
            pending_valid_d = 1'b1;
        end
        applied_d = frame_start & (config_accept | pending_valid_q);
        error_d   = config_valid_in ? ~config_ok : error_q;

        x_ext     = WIN_COORD_WIDTH'(x);
        y_ext     = WIN_COORD_WIDTH'(y);
        dx        = x_ext - active_d.x_start;
        dy        = y_ext - active_d.y_start;
        if (BAYER_MODE != 0) begin
            dx = dx >> 1;
            dy = dy >> 1;
        end
        step_mask = (WIN_COORD_WIDTH'(1) << active_d.decim) - WIN_COORD_WIDTH'(1);
        in_window = (x_ext >= active_d.x_start) && (x_ext < active_d.x_end) &&
                    (y_ext >= active_d.y_start) && (y_ext < active_d.y_end);
        keep      = line_valid_in && frame_valid_in && synced && in_window &&
                    ((dx & step_mask) == '0) && ((dy & step_mask) == '0);

        data_d        = keep ? data_in : data_q;
        line_valid_d  = keep;
        frame_valid_d = keep | (frame_valid_in & frame_valid_q);
        frame_count_d = (frame_valid_q & ~frame_valid_d) ? frame_count_q + 16'd1 : frame_count_q;
    end

    always_ff @(posedge pixel_clock_in or negedge mipi_byte_reset_n) begin
        if (!mipi_byte_reset_n) begin
            active_q        <= ACTIVE_RESET;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            error_q         <= 1'b0;
            applied_q       <= 1'b0;
            data_q          <= '0;
            line_valid_q    <= 1'b0;
            frame_valid_q   <= 1'b0;
            frame_count_q   <= '0;
        end else begin
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            error_q         <= error_d;
            applied_q       <= applied_d;
            data_q          <= data_d;
            line_valid_q    <= line_valid_d;
            frame_valid_q   <= frame_valid_d;
            frame_count_q   <= frame_count_d;
        end
    end

    assign data_out           = data_q;
    assign line_valid_out     = line_valid_q;
    assign frame_valid_out    = frame_valid_q;
    assign config_applied_out = applied_q;
    assign window_error_out   = error_q;
    assign frame_count_out    = frame_count_q;

endmodule

// File: tb/tb_window_crop_multi.sv
// Randomised frame-level bench: raw and Bayer instances against a window/decimation reference model.
module tb_window_crop_multi;

    localparam int unsigned CH = 2;
    localparam int unsigned DW = 10;
    localparam int unsigned CW = 12;
    localparam int unsigned PW = CH * DW;

    logic          pixel_clock_in    = 1'b0;
    logic          mipi_byte_reset_n = 1'b0;
    logic [PW-1:0] data_in           = '0;
    logic          line_valid_in     = 1'b0;
    logic          frame_valid_in    = 1'b0;
    logic [CW-1:0] x_start_in        = '0;
    logic [CW-1:0] x_end_in          = '0;
    logic [CW-1:0] y_start_in        = '0;
    logic [CW-1:0] y_end_in          = '0;
    logic [1:0]    decim_in          = '0;
    logic          config_valid_in   = 1'b0;

    logic [PW-1:0] data_out           [2];
    logic          line_valid_out     [2];
    logic          frame_valid_out    [2];
    logic          config_applied_out [2];
    logic          window_error_out   [2];
    logic [15:0]   frame_count_out    [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        window_crop_multi #(
            .CHANNELS   (CH),
            .DATA_WIDTH (DW),
            .COORD_WIDTH(CW),
            .MAX_DECIM  (3),
            .BAYER_MODE (gi)
        ) u_dut (
            .pixel_clock_in    (pixel_clock_in),
            .mipi_byte_reset_n (mipi_byte_reset_n),
            .data_in           (data_in),
            .line_valid_in     (line_valid_in),
            .frame_valid_in    (frame_valid_in),
            .x_start_in        (x_start_in),
            .x_end_in          (x_end_in),
            .y_start_in        (y_start_in),
            .y_end_in          (y_end_in),
            .decim_in          (decim_in),
            .config_valid_in   (config_valid_in),
            .data_out          (data_out[gi]),
            .line_valid_out    (line_valid_out[gi]),
            .frame_valid_out   (frame_valid_out[gi]),
            .config_applied_out(config_applied_out[gi]),
            .window_error_out  (window_error_out[gi]),
            .frame_count_out   (frame_count_out[gi])
        );
    end

    always #5 pixel_clock_in = ~pixel_clock_in;

    int unsigned cycle = 0;
    always @(posedge pixel_clock_in) cycle++;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state, kept in plain integers.
    typedef struct { int xs; int xe; int ys; int ye; int d; } win_t;
    typedef struct { logic [PW-1:0] data; int unsigned cyc; } exp_t;

    localparam win_t DEFAULT_WIN = '{0, 720, 0, 720, 0};

    win_t m_active, m_pending, cfg;
    bit   m_pend_valid;
    bit   m_err;
    int   m_applied_exp;
    int   m_count [2];
    exp_t exp_q [2][$];
    int   applied_seen [2];
    bit   fvo_seen [2];

    function automatic bit keep_px(input win_t w, input int x, input int y, input bit bayer);
        int dx, dy, step;
        if (x < w.xs || x >= w.xe || y < w.ys || y >= w.ye) return 1'b0;
        dx = x - w.xs;
        dy = y - w.ys;
        if (bayer) begin
            dx = dx / 2;
            dy = dy / 2;
        end
        step = 1 << w.d;
        return (dx % step == 0) && (dy % step == 0);
    endfunction

    task automatic model_config();
        bit ok;
        ok    = (cfg.xe > cfg.xs) && (cfg.ye > cfg.ys) && (cfg.d <= 3);
        m_err = !ok;
        if (ok) begin
            m_pending    = cfg;
            m_pend_valid = 1'b1;
        end
    endtask

    task automatic model_frame_start();
        if (m_pend_valid) begin
            m_active     = m_pending;
            m_pend_valid = 1'b0;
            m_applied_exp++;
        end
    endtask

    task automatic model_reset();
        m_active     = DEFAULT_WIN;
        m_pend_valid = 1'b0;
        m_err        = 1'b0;
        m_count[0]   = 0;
        m_count[1]   = 0;
    endtask

    task automatic tick();
        @(posedge pixel_clock_in);
        #1;
    endtask

    task automatic drive_cfg();
        config_valid_in = 1'b1;
        x_start_in      = CW'(cfg.xs);
        x_end_in        = CW'(cfg.xe);
        y_start_in      = CW'(cfg.ys);
        y_end_in        = CW'(cfg.ye);
        decim_in        = 2'(cfg.d);
        model_config();
    endtask

    task automatic config_idle();
        drive_cfg();
        tick();
        config_valid_in = 1'b0;
        for (int b = 0; b < 2; b++) check_eq("cfg_error", 64'(window_error_out[b]), 64'(m_err));
    endtask

    // cfg_at: -1 none, -2 on the frame_valid rising edge, else mid-line of that row.
    // rst_at: row where reset is pulsed mid-line, -1 for none.
    task automatic run_frame(input int w, input int h, input int cfg_at, input int rst_at);
        bit any [2];
        int ap0 [2];
        int ap_exp0;
        bit dead;
        int rst_hold;
        exp_t e;
        any[0] = 1'b0;
        any[1] = 1'b0;
        dead = 1'b0;
        rst_hold = 0;
        for (int b = 0; b < 2; b++) begin
            ap0[b]      = applied_seen[b];
            fvo_seen[b] = 1'b0;
        end
        ap_exp0 = m_applied_exp;
        repeat (3) tick();
        frame_valid_in = 1'b1;
        if (cfg_at == -2) drive_cfg();
        model_frame_start();
        tick();
        config_valid_in = 1'b0;
        repeat (2) tick();
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                line_valid_in = 1'b1;
                data_in       = PW'($urandom);
                if (cfg_at == y && x == w / 2) drive_cfg();
                if (rst_hold > 0) begin
                    rst_hold--;
                    if (rst_hold == 0) mipi_byte_reset_n = 1'b1;
                end
                if (rst_at == y && x == w / 2) begin
                    mipi_byte_reset_n = 1'b0;
                    dead = 1'b1;
                    rst_hold = 3;
                    #1;
                    for (int b = 0; b < 2; b++) begin
                        check_eq("rst_lvo", 64'(line_valid_out[b]), 64'd0);
                        check_eq("rst_fvo", 64'(frame_valid_out[b]), 64'd0);
                        check_eq("rst_data", 64'(data_out[b]), 64'd0);
                        check_eq("rst_count", 64'(frame_count_out[b]), 64'd0);
                        exp_q[b].delete();
                        any[b]      = 1'b0;
                        fvo_seen[b] = 1'b0;
                    end
                    model_reset();
                end
                if (!dead) begin
                    for (int b = 0; b < 2; b++) begin
                        if (keep_px(m_active, x, y, b[0])) begin
                            e.data = data_in;
                            e.cyc  = cycle;
                            exp_q[b].push_back(e);
                            any[b] = 1'b1;
                        end
                    end
                end
                tick();
                config_valid_in = 1'b0;
            end
            line_valid_in = 1'b0;
            repeat (2) tick();
        end
        frame_valid_in = 1'b0;
        repeat (4) tick();
        for (int b = 0; b < 2; b++) begin
            if (any[b]) m_count[b] = (m_count[b] + 1) & 16'hFFFF;
            check_eq("frame_count", 64'(frame_count_out[b]), 64'(m_count[b]));
            check_eq("fvo_seen", 64'(fvo_seen[b]), 64'(any[b]));
            check_eq("queue_drained", 64'(exp_q[b].size()), 64'd0);
            check_eq("applied", 64'(applied_seen[b] - ap0[b]), 64'(m_applied_exp - ap_exp0));
            check_eq("window_error", 64'(window_error_out[b]), 64'(m_err));
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_mon
        logic fvo_prev = 1'b0;
        always @(negedge pixel_clock_in) begin
            exp_t e;
            if (config_applied_out[gi]) applied_seen[gi]++;
            if (frame_valid_out[gi]) fvo_seen[gi] = 1'b1;
            if (frame_valid_out[gi] && !fvo_prev) begin
                check_eq("fvo_rise_with_lvo", 64'(line_valid_out[gi]), 64'd1);
            end
            fvo_prev = frame_valid_out[gi];
            if (line_valid_out[gi]) begin
                if (exp_q[gi].size() == 0) begin
                    check_eq("unexpected_pixel", 64'(exp_q[gi].size()), 64'd1);
                end else begin
                    e = exp_q[gi].pop_front();
                    check_eq("pixel", {cycle, 12'd0, data_out[gi]}, {e.cyc + 32'd1, 12'd0, e.data});
                end
            end
        end
    end

    initial begin
        int w, h, sel, cat;
        m_applied_exp   = 0;
        applied_seen[0] = 0;
        applied_seen[1] = 0;
        model_reset();

        repeat (3) @(posedge pixel_clock_in);
        #1;
        for (int b = 0; b < 2; b++) begin
            check_eq("reset_data", 64'(data_out[b]), 64'd0);
            check_eq("reset_lvo", 64'(line_valid_out[b]), 64'd0);
            check_eq("reset_fvo", 64'(frame_valid_out[b]), 64'd0);
            check_eq("reset_applied", 64'(config_applied_out[b]), 64'd0);
            check_eq("reset_error", 64'(window_error_out[b]), 64'd0);
            check_eq("reset_count", 64'(frame_count_out[b]), 64'd0);
        end
        mipi_byte_reset_n = 1'b1;
        tick();

        // Default window clips a 724-wide frame at column 720.
        run_frame(724, 3, -1, -1);

        // Mid-frame config only takes effect on the following frame.
        cfg = '{284, 1004, 4, 724, 0};
        run_frame(300, 10, 4, -1);
        run_frame(300, 10, -1, -1);

        cfg = '{0, 8, 0, 4, 1};
        config_idle();
        run_frame(12, 6, -1, -1);

        // Rejected config leaves pending untouched; a later good one clears the error.
        cfg = '{100, 100, 0, 4, 0};
        config_idle();
        run_frame(12, 6, -1, -1);
        cfg = '{2, 10, 1, 5, 0};
        config_idle();
        run_frame(12, 6, -1, -1);

        // Reset mid-line: rest of frame dropped, default window afterwards.
        run_frame(16, 6, -1, 2);
        run_frame(16, 6, -1, -1);

        // Window below the frame, configured on the frame_valid rising edge.
        cfg = '{0, 4, 800, 900, 0};
        run_frame(4, 728, -2, -1);

        for (int i = 0; i < 10; i++) begin
            w   = int'($urandom_range(6, 20));
            h   = int'($urandom_range(3, 10));
            cfg = '{int'($urandom_range(0, w)), int'($urandom_range(0, w + 2)),
                    int'($urandom_range(0, h)), int'($urandom_range(0, h + 2)),
                    int'($urandom_range(0, 3))};
            sel = int'($urandom_range(0, 3));
            cat = (sel == 0) ? -1 : (sel == 1) ? -2 : int'($urandom_range(0, h - 1));
            if (sel == 3) config_idle();
            run_frame(w, h, (sel == 3) ? -1 : cat, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
